// File: rtl/dds_cmd_pkg.sv
// Shared definitions for the DDS command executor: command codes, register
// addresses, serial frame geometry, FSM states and frame-building helpers.
package dds_cmd_pkg;

  localparam logic [3:0] CMD_NOP    = 4'h0;
  localparam logic [3:0] CMD_FTW    = 4'h1;
  localparam logic [3:0] CMD_POW    = 4'h2;
  localparam logic [3:0] CMD_ASF    = 4'h3;
  localparam logic [3:0] CMD_UPDATE = 4'h4;
  localparam logic [3:0] CMD_MRESET = 4'h5;

  localparam logic [4:0] ADDR_FTW = 5'h04;
  localparam logic [4:0] ADDR_POW = 5'h05;
  localparam logic [4:0] ADDR_ASF = 5'h06;

  // Longest frame is FTW: 8-bit instruction + 32 data bits.
  localparam int FRAME_W = 40;
  localparam int LEN_W   = 6;

  localparam logic [LEN_W-1:0] LEN_FTW = 6'd40;
  localparam logic [LEN_W-1:0] LEN_16  = 6'd24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_UPDATE,
    ST_MRESET,
    ST_DONE
  } state_e;

  // Frame is left-aligned so the shifter always sends from bit FRAME_W-1.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0]  cmd,
                                                      input logic [31:0] data);
    case (cmd)
      CMD_FTW: return {3'b000, ADDR_FTW, data};
      CMD_POW: return {3'b000, ADDR_POW, data[15:0], 16'h0000};
      CMD_ASF: return {3'b000, ADDR_ASF, 2'b00, data[13:0], 16'h0000};
      default: return '0;
    endcase
  endfunction

  function automatic logic [LEN_W-1:0] frame_len(input logic [3:0] cmd);
    case (cmd)
      CMD_FTW:          return LEN_FTW;
      CMD_POW, CMD_ASF: return LEN_16;
      default:          return '0;
    endcase
  endfunction

  function automatic logic cmd_known(input logic [3:0] cmd);
    return (cmd <= CMD_MRESET);
  endfunction

endpackage

// File: rtl/dds_cmd_exec_if.sv
// Command handshake from the pulse sequencer plus the DDS serial/strobe pins.
interface dds_cmd_exec_if;

  logic [3:0]  ddscmd_i;
  logic [31:0] ddsdata_i;
  logic        ddscmd_trig_i;
  logic        ddsready_o;
  logic        dds_sclk_o;
  logic        dds_sdio_o;
  logic        dds_cs_n_o;
  logic        dds_ioupdate_o;
  logic        dds_mrst_o;
  logic        cmd_err_o;
  logic        overrun_o;

  modport master (
    output ddscmd_i, ddsdata_i, ddscmd_trig_i,
    input  ddsready_o, dds_sclk_o, dds_sdio_o, dds_cs_n_o,
    input  dds_ioupdate_o, dds_mrst_o, cmd_err_o, overrun_o
  );

  modport slave (
    input  ddscmd_i, ddsdata_i, ddscmd_trig_i,
    output ddsready_o, dds_sclk_o, dds_sdio_o, dds_cs_n_o,
    output dds_ioupdate_o, dds_mrst_o, cmd_err_o, overrun_o
  );

endinterface

// File: rtl/spi_shift_tx.sv
// Mode-0 SPI serializer: shifts `len` bits MSB first, each bit CLK_DIV cycles
// low then CLK_DIV cycles high, followed by a CLK_DIV-cycle low tail.
module spi_shift_tx
  import dds_cmd_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [FRAME_W-1:0] word,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  output logic               done,
  output logic               sclk,
  output logic               sdio
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic               busy_q;
  logic               sclk_q;
  logic               tail_q;
  logic [LEN_W-1:0]   bit_cnt;
  logic [7:0]         div_cnt;
  logic [FRAME_W-1:0] sreg;
  logic               half_end;

  assign half_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      tail_q  <= 1'b0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (!busy_q) begin
      if (load) begin
        busy_q  <= 1'b1;
        sclk_q  <= 1'b0;
        tail_q  <= 1'b0;
        bit_cnt <= len - LEN_W'(1);
        div_cnt <= '0;
      end
    end else if (!half_end) begin
      div_cnt <= div_cnt + 8'd1;
    end else begin
      div_cnt <= '0;
      if (tail_q) begin
        busy_q <= 1'b0;
        tail_q <= 1'b0;
      end else if (!sclk_q) begin
        sclk_q <= 1'b1;
      end else begin
        sclk_q <= 1'b0;
        if (bit_cnt == '0) tail_q  <= 1'b1;
        else               bit_cnt <= bit_cnt - LEN_W'(1);
      end
    end
  end

  // Data advances on the SCLK falling edge so SDIO is stable while SCLK is high.
  always_ff @(posedge clk) begin
    if (load && !busy_q)
      sreg <= word;
    else if (busy_q && half_end && sclk_q && !tail_q)
      sreg <= {sreg[FRAME_W-2:0], 1'b0};
  end

  assign busy = busy_q;
  assign done = busy_q & tail_q & half_end;
  assign sclk = sclk_q;
  assign sdio = busy_q & ~tail_q & sreg[FRAME_W-1];

endmodule

// File: rtl/dds_cmd_exec.sv
// DDS command executor: accepts sequencer commands and turns them into SPI
// register writes, IO_UPDATE strobes or master-reset pulses.
module dds_cmd_exec
  import dds_cmd_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int IOUPD_LEN = 4,
  parameter int MRST_LEN  = 8
) (
  input  logic           clk_i,
  input  logic           reset_i,
  dds_cmd_exec_if.slave  bus
);

  localparam int CNT_W = 16;

  state_e             state;
  state_e             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               accept;
  logic               spi_load;
  logic               spi_busy;
  logic               spi_done;
  logic               spi_sclk;
  logic               spi_sdio;
  logic               ready_q;
  logic               ioupd_q;
  logic               mrst_q;
  logic               err_q;
  logic               ovr_q;

  assign accept = bus.ddscmd_trig_i && (state == ST_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    spi_load  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          case (bus.ddscmd_i)
            CMD_FTW, CMD_POW, CMD_ASF: begin
              state_nxt = ST_SHIFT;
              spi_load  = 1'b1;
            end
            CMD_UPDATE: begin
              state_nxt = ST_UPDATE;
              cnt_nxt   = '0;
            end
            CMD_MRESET: begin
              state_nxt = ST_MRESET;
              cnt_nxt   = '0;
            end
            default: state_nxt = ST_DONE;
          endcase
        end
      end
      ST_SHIFT: begin
        if (spi_done) begin
          state_nxt = ST_UPDATE;
          cnt_nxt   = '0;
        end
      end
      ST_UPDATE: begin
        if (cnt == CNT_W'(IOUPD_LEN - 1)) state_nxt = ST_DONE;
        else                              cnt_nxt   = cnt + CNT_W'(1);
      end
      ST_MRESET: begin
        if (cnt == CNT_W'(MRST_LEN - 1)) state_nxt = ST_DONE;
        else                             cnt_nxt   = cnt + CNT_W'(1);
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Strobe outputs are registered from the next state so they stay glitch-free.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ready_q <= 1'b1;
      ioupd_q <= 1'b0;
      mrst_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ready_q <= (state_nxt == ST_IDLE);
      ioupd_q <= (state_nxt == ST_UPDATE);
      mrst_q  <= (state_nxt == ST_MRESET);
      err_q   <= accept && !cmd_known(bus.ddscmd_i);
      ovr_q   <= bus.ddscmd_trig_i && (state != ST_IDLE);
    end
  end

  spi_shift_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_spi (
    .clk  (clk_i),
    .rst  (reset_i),
    .load (spi_load),
    .word (build_frame(bus.ddscmd_i, bus.ddsdata_i)),
    .len  (frame_len(bus.ddscmd_i)),
    .busy (spi_busy),
    .done (spi_done),
    .sclk (spi_sclk),
    .sdio (spi_sdio)
  );

  assign bus.ddsready_o     = ready_q;
  assign bus.dds_sclk_o     = spi_sclk;
  assign bus.dds_sdio_o     = spi_sdio;
  assign bus.dds_cs_n_o     = ~spi_busy;
  assign bus.dds_ioupdate_o = ioupd_q;
  assign bus.dds_mrst_o     = mrst_q;
  assign bus.cmd_err_o      = err_q;
  assign bus.overrun_o      = ovr_q;

endmodule

// File: tb/tb_dds_cmd_exec.sv
// Randomized bench for dds_cmd_exec against a transaction-level expectation
// model built from the command table and timing rules.
module tb_dds_cmd_exec;
  import dds_cmd_pkg::*;

  localparam int D = 2;
  localparam int L = 4;
  localparam int M = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  dds_cmd_exec_if bus();

  dds_cmd_exec #(
    .CLK_DIV   (D),
    .IOUPD_LEN (L),
    .MRST_LEN  (M)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no_finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command at the current negedge and observe until ready returns.
  task automatic run_cmd(input logic [3:0] cmd, input logic [31:0] data, input int ovr_at);
    int          n, addr, k;
    logic [31:0] pay;
    logic [63:0] exp_frame, cap;
    int          exp_cs, exp_iou, exp_first, exp_lat, exp_mrst, exp_err, exp_err_cyc;
    int          cs_low, nbits, iou, first_iou, mrst, err, err_cyc, ovr, sdio_bad, idle_bad;
    logic        prev_sclk, prev_sdio, done;

    n = 0; addr = 0; pay = '0; exp_frame = '0;
    exp_cs = 0; exp_iou = 0; exp_first = -1; exp_lat = 2; exp_mrst = 0;
    exp_err = 0; exp_err_cyc = -1;
    case (cmd)
      4'h1: begin n = 40; addr = 4; pay = data; end
      4'h2: begin n = 24; addr = 5; pay = data & 32'h0000_FFFF; end
      4'h3: begin n = 24; addr = 6; pay = data & 32'h0000_3FFF; end
      default: ;
    endcase
    if (n > 0) begin
      exp_frame = (64'(addr) << (n - 8)) | 64'(pay);
      exp_cs    = (2 * n + 1) * D;
      exp_iou   = L;
      exp_first = exp_cs + 1;
      exp_lat   = exp_cs + L + 2;
    end else if (cmd == 4'h4) begin
      exp_iou = L; exp_first = 1; exp_lat = L + 2;
    end else if (cmd == 4'h5) begin
      exp_mrst = M; exp_lat = M + 2;
    end else if (cmd != 4'h0) begin
      exp_err = 1; exp_err_cyc = 1;
    end

    cs_low = 0; nbits = 0; iou = 0; first_iou = -1; mrst = 0; err = 0;
    err_cyc = -1; ovr = 0; sdio_bad = 0; idle_bad = 0; cap = '0;
    prev_sclk = 1'b0; prev_sdio = 1'b0; done = 1'b0; k = 0;

    bus.ddscmd_i      = cmd;
    bus.ddsdata_i     = data;
    bus.ddscmd_trig_i = 1'b1;
    while (!done && k < 2000) begin
      @(negedge clk);
      k++;
      if (k == ovr_at) begin
        bus.ddscmd_i      = CMD_POW;
        bus.ddsdata_i     = $urandom;
        bus.ddscmd_trig_i = 1'b1;
      end else begin
        bus.ddscmd_trig_i = 1'b0;
      end
      if (!bus.dds_cs_n_o) cs_low++;
      if (!bus.dds_cs_n_o && bus.dds_sclk_o && !prev_sclk) begin
        cap = {cap[62:0], bus.dds_sdio_o};
        nbits++;
      end
      if (bus.dds_sclk_o && (bus.dds_sdio_o != prev_sdio)) sdio_bad++;
      if (bus.dds_cs_n_o && (bus.dds_sclk_o || bus.dds_sdio_o)) idle_bad++;
      if (bus.dds_ioupdate_o) begin
        iou++;
        if (first_iou < 0) first_iou = k;
      end
      if (bus.dds_mrst_o) mrst++;
      if (bus.cmd_err_o) begin
        err++;
        if (err_cyc < 0) err_cyc = k;
      end
      if (bus.overrun_o) ovr++;
      prev_sclk = bus.dds_sclk_o;
      prev_sdio = bus.dds_sdio_o;
      if (bus.ddsready_o) done = 1'b1;
    end
    bus.ddscmd_trig_i = 1'b0;

    chk($sformatf("timeout_c%0h", cmd),   64'(done), 64'(1));
    chk($sformatf("latency_c%0h", cmd),   64'(k), 64'(exp_lat));
    chk($sformatf("cs_low_c%0h", cmd),    64'(cs_low), 64'(exp_cs));
    chk($sformatf("nbits_c%0h", cmd),     64'(nbits), 64'(n));
    chk($sformatf("frame_c%0h", cmd),     cap, exp_frame);
    chk($sformatf("ioupd_len_c%0h", cmd), 64'(iou), 64'(exp_iou));
    chk($sformatf("ioupd_at_c%0h", cmd),  64'(first_iou), 64'(exp_first));
    chk($sformatf("mrst_len_c%0h", cmd),  64'(mrst), 64'(exp_mrst));
    chk($sformatf("cmd_err_c%0h", cmd),   64'(err), 64'(exp_err));
    chk($sformatf("cmd_err_at_c%0h", cmd), 64'(err_cyc), 64'(exp_err_cyc));
    chk($sformatf("overrun_c%0h", cmd),   64'(ovr), 64'((ovr_at > 0) ? 1 : 0));
    chk($sformatf("sdio_hold_c%0h", cmd), 64'(sdio_bad), 64'(0));
    chk($sformatf("idle_pins_c%0h", cmd), 64'(idle_bad), 64'(0));
  endtask

  task automatic quiet(input int cycles, input string tag);
    int act;
    act = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (!bus.dds_cs_n_o || bus.dds_ioupdate_o || bus.dds_mrst_o ||
          bus.cmd_err_o || bus.overrun_o || !bus.ddsready_o) act++;
    end
    chk(tag, 64'(act), 64'(0));
  endtask

  task automatic reset_mid();
    int iou, csl, mr, nr;
    iou = 0; csl = 0; mr = 0; nr = 0;
    bus.ddscmd_i      = CMD_FTW;
    bus.ddsdata_i     = $urandom;
    bus.ddscmd_trig_i = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.ddscmd_trig_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_cs_n",  64'(bus.dds_cs_n_o), 64'(1));
    chk("rst_mid_ready", 64'(bus.ddsready_o), 64'(1));
    repeat (30) begin
      @(negedge clk);
      if (bus.dds_ioupdate_o) iou++;
      if (!bus.dds_cs_n_o) csl++;
    end
    chk("rst_mid_no_ioupd", 64'(iou), 64'(0));
    chk("rst_mid_no_cs",    64'(csl), 64'(0));

    bus.ddscmd_i      = CMD_MRESET;
    bus.ddscmd_trig_i = 1'b1;
    rst               = 1'b1;
    @(negedge clk);
    bus.ddscmd_trig_i = 1'b0;
    rst               = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.dds_mrst_o) mr++;
      if (!bus.ddsready_o) nr++;
    end
    chk("rst_strobe_no_mrst", 64'(mr), 64'(0));
    chk("rst_strobe_ready",   64'(nr), 64'(0));
  endtask

  initial begin
    logic [3:0] c;
    int         o;

    rst               = 1'b1;
    bus.ddscmd_i      = '0;
    bus.ddsdata_i     = '0;
    bus.ddscmd_trig_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready",   64'(bus.ddsready_o),     64'(1));
    chk("rst_cs_n",    64'(bus.dds_cs_n_o),     64'(1));
    chk("rst_sclk",    64'(bus.dds_sclk_o),     64'(0));
    chk("rst_sdio",    64'(bus.dds_sdio_o),     64'(0));
    chk("rst_ioupd",   64'(bus.dds_ioupdate_o), 64'(0));
    chk("rst_mrst",    64'(bus.dds_mrst_o),     64'(0));
    chk("rst_cmd_err", 64'(bus.cmd_err_o),      64'(0));
    chk("rst_overrun", 64'(bus.overrun_o),      64'(0));

    run_cmd(CMD_FTW, 32'h1234_5678, 0);
    run_cmd(CMD_ASF, 32'hFFFF_FFFF, 0);
    run_cmd(CMD_FTW, $urandom, 10);
    quiet(20, "overrun_no_pow");
    run_cmd(4'h9, $urandom, 0);
    run_cmd(CMD_NOP, $urandom, 0);
    run_cmd(CMD_UPDATE, $urandom, 0);
    run_cmd(CMD_MRESET, $urandom, 0);
    reset_mid();
    run_cmd(CMD_POW, $urandom, 0);

    for (int i = 0; i < 16; i++) begin
      c = 4'($urandom_range(0, 15));
      o = ((c == CMD_FTW || c == CMD_POW || c == CMD_ASF) && $urandom_range(0, 1) == 1)
          ? int'($urandom_range(1, 40)) : 0;
      run_cmd(c, $urandom, o);
    end
    quiet(10, "final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dds_cmd_exec.md
DDS_CMD_EXEC -- requirements
Module: dds_cmd_exec

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: clk_i cycles per SCLK half-period; legal range 1..255.
REQ-002 SHALL have parameter IOUPD_LEN, default 4: width of the IO_UPDATE pulse, in clk_i cycles.
REQ-003 SHALL have parameter MRST_LEN, default 8: width of the DDS master-reset pulse, in clk_i cycles.
REQ-004 SHALL run on one clock with a synchronous, active-high reset.
REQ-005 Ports, as name / direction / width / meaning:
- clk_i / in / 1 / system clock.
- reset_i / in / 1 / synchronous active-high reset.
- ddscmd_i / in / 4 / command code from the pulse sequencer.
- ddsdata_i / in / 32 / command operand.
- ddscmd_trig_i / in / 1 / one-cycle command strobe.
- ddsready_o / out / 1 / high when idle and able to accept a command.
- dds_sclk_o / out / 1 / serial clock.
- dds_sdio_o / out / 1 / serial data, MSB first.
- dds_cs_n_o / out / 1 / chip select, active low.
- dds_ioupdate_o / out / 1 / IO_UPDATE strobe to the DDS.
- dds_mrst_o / out / 1 / master reset to the DDS.
- cmd_err_o / out / 1 / one-cycle pulse: command code not recognised.
- overrun_o / out / 1 / one-cycle pulse: strobe arrived while busy.

Function
REQ-006 SHALL accept a command only when ddscmd_trig_i=1 and ddsready_o=1; on acceptance it latches ddscmd_i and ddsdata_i in that cycle, and ddsready_o=0 from the next cycle.
REQ-007 SHALL ignore any strobe that arrives while ddsready_o=0, SHALL pulse overrun_o for one cycle, and SHALL leave the operation in progress undisturbed.
REQ-008 Command codes:
- 0x1 FTW: address 0x04, 32 data bits = ddsdata_i[31:0].
- 0x2 POW: address 0x05, 16 data bits = ddsdata_i[15:0].
- 0x3 ASF: address 0x06, 16 data bits = {2'b00, ddsdata_i[13:0]}.
- 0x4 UPDATE: IO_UPDATE pulse only.
- 0x5 MRESET: master-reset pulse only.
- 0x0 NOP: no output activity.
REQ-009 Any other code SHALL pulse cmd_err_o one cycle after acceptance, produce no serial or pulse activity, and return to IDLE.
REQ-010 State machine states: IDLE, SHIFT, UPDATE, MRESET, DONE.
- IDLE goes to SHIFT (codes 1..3), UPDATE (code 4), MRESET (code 5), or DONE (NOP or illegal code).
- SHIFT goes to UPDATE.
- UPDATE goes to DONE.
- MRESET goes to DONE.
- DONE goes to IDLE after one cycle; ddsready_o returns to 1 on entry to IDLE.
REQ-011 Serial frame SHALL be an 8-bit instruction {1'b0 (write), 2'b00, addr[4:0]} followed by the data bits, all MSB first.
REQ-012 SPI SHALL be mode 0:
- dds_cs_n_o falls on SHIFT entry.
- dds_sdio_o changes only while dds_sclk_o=0.
- Each bit is CLK_DIV cycles with SCLK low, then CLK_DIV cycles with SCLK high.
- dds_cs_n_o rises CLK_DIV cycles after the last falling SCLK edge.
REQ-013 SHIFT duration SHALL be (2*N+1)*CLK_DIV cycles, with N=40 (FTW) or N=24 (POW/ASF).
REQ-014 UPDATE SHALL drive dds_ioupdate_o=1 for exactly IOUPD_LEN cycles, starting the cycle after dds_cs_n_o rises, or after acceptance for code 4.
REQ-015 MRESET SHALL drive dds_mrst_o=1 for exactly MRST_LEN cycles.
REQ-016 Acceptance-to-ready latency SHALL be:
- NOP/illegal: 2 cycles.
- UPDATE: IOUPD_LEN+2 cycles.
- MRESET: MRST_LEN+2 cycles.
- FTW: 81*CLK_DIV+IOUPD_LEN+2 cycles.
REQ-017 Outside SHIFT: dds_sclk_o=0, dds_sdio_o=0, dds_cs_n_o=1.

Reset
REQ-018 reset_i=1 SHALL on the next edge force IDLE and set:
- ddsready_o=1, dds_cs_n_o=1.
- dds_sclk_o=0, dds_sdio_o=0, dds_ioupdate_o=0, dds_mrst_o=0, cmd_err_o=0, overrun_o=0.
REQ-019 Reset mid-SHIFT SHALL abort the frame with no IO_UPDATE issued; a strobe coincident with reset_i=1 SHALL be dropped.

Structure
REQ-020 Package dds_cmd_pkg SHALL hold the command codes, register addresses, frame lengths and the state enumeration.
REQ-021 Serialization SHALL live in one sub-module, spi_shift_tx (load, length, busy, done; CLK_DIV parameter).

Verification
REQ-022 FTW: CLK_DIV=2, cmd=0x1, data=0x12345678.
- Required: instruction byte 0x04 then 0x12345678, captured on rising SCLK edges.
- cs_n low for 162 cycles.
- ioupdate high 4 cycles.
- ready back after 168 cycles.
REQ-023 ASF: cmd=0x3, data=0xFFFFFFFF.
- Required: shifted word 0x06 then 0x3FFF.
REQ-024 Overrun: second strobe (cmd=0x2) 10 cycles into an FTW.
- Required: overrun_o pulses once; the FTW frame is unchanged; no POW frame is sent.
REQ-025 Illegal and NOP: cmd=0x9.
- Required: cmd_err_o pulses, no cs_n activity, ready after 2 cycles.
- cmd=0x0: no cmd_err_o.
REQ-026 Reset at cycle 40 of an FTW.
- Required: cs_n=1 and ready=1 the next cycle, no ioupdate; a following POW strobe then completes normally.
REQ-027 MRESET: cmd=0x5.
- Required: dds_mrst_o high exactly 8 cycles, ready after 10 cycles.
